modulo_r_cascade: RTL and testbench

Multi-digit modulo-R counter that sits directly downstream of a single-stage modulo-R counter and consumes its carry pulse as its count enable. It extends the count range by chaining DIGITS modulo-MODULUS digits with ripple-free carry lookahead. It adds a synchronous clear, a hold, a sticky overflow flag and a programmable target compare for the next stage, for example a display or an alarm block.

---
 rtl/modulo_r_cascade_pkg.sv | 18 +
 rtl/modulo_r_cascade_digit.sv | 37 +++
 rtl/modulo_r_cascade.sv | 106 ++++++++++
 tb/tb_modulo_r_cascade.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_r_cascade_pkg.sv
// Shared defaults for the modulo-R cascade counter.
// Contents:
//   DEF_DIGITS / DEF_MODULUS / DEF_WIDTH  default geometry
//   DEF_TERMINAL                          terminal digit value (MODULUS-1) at the default width
//   terminal_value()                      terminal digit value for any modulus
package modulo_r_cascade_pkg;

  localparam int DEF_DIGITS  = 4;
  localparam int DEF_MODULUS = 10;
  localparam int DEF_WIDTH   = 4;

  localparam logic [DEF_WIDTH-1:0] DEF_TERMINAL = DEF_WIDTH'(DEF_MODULUS - 1);

  function automatic int terminal_value(input int modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/modulo_r_cascade_digit.sv
// Single modulo-MODULUS digit of the cascade.
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-high reset, q -> 0
//   clear   synchronous clear, q -> 0
//   inc     advance this digit on the next edge
//   q       digit value, 0..MODULUS-1
//   at_max  q is at the terminal value MODULUS-1
module modulo_digit
  import modulo_r_cascade_pkg::*;
#(
  parameter int MODULUS = DEF_MODULUS,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] q,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(terminal_value(MODULUS));

  assign at_max = (q == TERM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (inc) begin
      q <= at_max ? '0 : q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/modulo_r_cascade.sv
// Multi-digit modulo-R counter fed by an upstream counter's carry.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset of all state
//   enable       count tick (upstream cout)
//   hold         freeze count, enable ignored
//   clear        synchronous clear of count and overflow
//   load_target  capture target_in into the target register
//   target_in    compare value, digit 0 in LSBs
//   qout         count value, digit 0 in LSBs
//   cout         terminal carry (combinational), feeds the next cascade
//   overflow     sticky full-wrap flag
//   match        registered qout == target
module modulo_r_cascade
  import modulo_r_cascade_pkg::*;
#(
  parameter int DIGITS  = DEF_DIGITS,
  parameter int MODULUS = DEF_MODULUS,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    hold,
  input  logic                    clear,
  input  logic                    load_target,
  input  logic [DIGITS*WIDTH-1:0] target_in,
  output logic [DIGITS*WIDTH-1:0] qout,
  output logic                    cout,
  output logic                    overflow,
  output logic                    match
);

  localparam int QW = DIGITS * WIDTH;
  localparam logic [WIDTH-1:0] TERM = WIDTH'(terminal_value(MODULUS));

  logic              inc;
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] at_max;
  logic [QW-1:0]     target;
  logic [QW-1:0]     target_next;
  logic [QW-1:0]     q_next;
  logic              tgt_valid;
  logic              match_next;

  assign inc      = enable & ~hold & ~clear;
  assign carry[0] = inc;

  // carry[k] is the AND of inc with at_max of every lower digit, so all
  // digits update on the same edge; nothing ripples across cycles.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    modulo_digit #(
      .MODULUS (MODULUS),
      .WIDTH   (WIDTH)
    ) u_digit (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear),
      .inc    (carry[g]),
      .q      (qout[g*WIDTH +: WIDTH]),
      .at_max (at_max[g])
    );
    assign carry[g+1] = carry[g] & at_max[g];
  end

  assign cout = carry[DIGITS];

  assign target_next = load_target ? target_in : target;

  // Mirror of the digit update so match can be registered against the value
  // qout will show after this edge.
  always_comb begin
    q_next    = qout;
    tgt_valid = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (clear) begin
        q_next[d*WIDTH +: WIDTH] = '0;
      end else if (carry[d]) begin
        q_next[d*WIDTH +: WIDTH] = at_max[d] ? '0 : qout[d*WIDTH +: WIDTH] + WIDTH'(1);
      end
      // Out-of-range target digits are rejected explicitly so a target can
      // never match, even if the count logic were ever to leave its range.
      if (target_next[d*WIDTH +: WIDTH] > TERM) begin
        tgt_valid = 1'b0;
      end
    end
    match_next = tgt_valid && (q_next == target_next);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target   <= '0;
      overflow <= 1'b0;
      match    <= 1'b0;
    end else begin
      target <= target_next;
      match  <= match_next;
      if (clear) begin
        overflow <= 1'b0;
      end else if (cout) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_modulo_r_cascade.sv
module tb_modulo_r_cascade;

  localparam int D = 2;
  localparam int M = 10;
  localparam int W = 4;

  logic           clk;
  logic           reset;
  logic           enable;
  logic           hold;
  logic           clear;
  logic           load_target;
  logic [D*W-1:0] target_in;
  logic [D*W-1:0] qout;
  logic           cout;
  logic           overflow;
  logic           match;

  int   checks;
  int   errors;
  logic cout_pre;
  logic cout_seen;
  logic match_seen;
  logic [7:0] expq;

  typedef struct {
    logic       en;
    logic       hd;
    logic       cl;
    logic       ld;
    logic [7:0] tgt;
    logic [7:0] exp_q;
    logic       exp_cout;
    logic       exp_ovf;
    logic       exp_match;
  } vec_t;

  vec_t vecs[10];

  modulo_r_cascade #(
    .DIGITS  (D),
    .MODULUS (M),
    .WIDTH   (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .hold        (hold),
    .clear       (clear),
    .load_target (load_target),
    .target_in   (target_in),
    .qout        (qout),
    .cout        (cout),
    .overflow    (overflow),
    .match       (match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic en, hd, cl, ld, input logic [7:0] tgt,
                              input logic [7:0] eq, input logic ec, eo, em);
    vec_t v;
    v.en = en; v.hd = hd; v.cl = cl; v.ld = ld; v.tgt = tgt;
    v.exp_q = eq; v.exp_cout = ec; v.exp_ovf = eo; v.exp_match = em;
    return v;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo == 4'd9) begin
      lo = 4'd0;
      hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Called just after a rising edge: drive, sample combinational cout, then
  // return 1 time unit after the next rising edge.
  task automatic step(input logic en, hd, cl, ld, input logic [7:0] tgt);
    enable      = en;
    hold        = hd;
    clear       = cl;
    load_target = ld;
    target_in   = tgt;
    #2;
    cout_pre = cout;
    if (cout === 1'b1) cout_seen = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cout_seen = 1'b0;
    reset = 1'b1;
    enable = 1'b0;
    hold = 1'b0;
    clear = 1'b0;
    load_target = 1'b0;
    target_in = '0;

    vecs[0] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    vecs[2] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0);
    vecs[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0);
    vecs[4] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0, 1'b1);
    vecs[5] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0, 1'b1);
    vecs[6] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 8'h04, 1'b0, 1'b0, 1'b1);
    vecs[7] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[8] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    vecs[9] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset state while reset is held
    #3;
    chk8("reset_q", qout, 8'h00);
    chk1("reset_cout", cout, 1'b0);
    chk1("reset_ovf", overflow, 1'b0);
    chk1("reset_match", match, 1'b0);
    #9;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].en, vecs[i].hd, vecs[i].cl, vecs[i].ld, vecs[i].tgt);
      chk1($sformatf("vec%0d_cout", i), cout_pre, vecs[i].exp_cout);
      chk8($sformatf("vec%0d_q", i), qout, vecs[i].exp_q);
      chk1($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
      chk1($sformatf("vec%0d_match", i), match, vecs[i].exp_match);
    end

    // 10 isolated pulses from zero
    cout_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    chk8("ten_pulses_q", qout, 8'h10);
    chk1("ten_pulses_ovf", overflow, 1'b0);
    chk1("ten_pulses_no_cout", cout_seen, 1'b0);

    // Up to 99, then the wrapping tick
    for (int i = 0; i < 89; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    chk8("preload_99", qout, 8'h99);
    chk1("cout_idle_at_99", cout, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk1("wrap_cout", cout_pre, 1'b1);
    chk8("wrap_q", qout, 8'h00);
    chk1("wrap_ovf", overflow, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    chk8("post_wrap_q", qout, 8'h05);
    chk1("ovf_sticky", overflow, 1'b1);

    // Continuous 37 cycles, then hold with enable
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk8("clear_q", qout, 8'h00);
    chk1("clear_ovf", overflow, 1'b0);
    for (int i = 0; i < 37; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk8("b2b_37", qout, 8'h37);
    cout_seen = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk8("hold_q", qout, 8'h37);
    chk1("hold_no_cout", cout_seen, 1'b0);

    // Wrap to set overflow, reach 42, then clear together with enable
    cout_seen = 1'b0;
    for (int i = 0; i < 105; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk8("reach_42", qout, 8'h42);
    chk1("ovf_at_42", overflow, 1'b1);
    chk1("cout_on_wrap_run", cout_seen, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk1("clear_en_cout", cout_pre, 1'b0);
    chk8("clear_en_q", qout, 8'h00);
    chk1("clear_en_ovf", overflow, 1'b0);

    // Target compare at 25
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h25);
    chk1("load25_match", match, 1'b0);
    expq = 8'h00;
    for (int i = 0; i < 26; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      expq = bcd_inc(expq);
      chk8("t25_q", qout, expq);
      chk1($sformatf("t25_match_at_%0h", expq), match, (expq == 8'h25));
    end

    // Invalid target digit never matches
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h3A);
    match_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      if (match === 1'b1) match_seen = 1'b1;
    end
    chk1("t3A_never_match", match_seen, 1'b0);
    chk8("t3A_q", qout, 8'h26);

    // Reach 57 with matching target, then async reset between edges
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h57);
    for (int i = 0; i < 31; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk8("pre_reset_q", qout, 8'h57);
    chk1("pre_reset_match", match, 1'b1);
    chk1("pre_reset_ovf", overflow, 1'b1);
    enable = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk8("async_reset_q", qout, 8'h00);
    chk1("async_reset_ovf", overflow, 1'b0);
    chk1("async_reset_match", match, 1'b0);
    chk1("async_reset_cout", cout, 1'b0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk8("resume_q1", qout, 8'h01);
    chk1("resume_match", match, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk8("resume_q2", qout, 8'h02);
    chk1("resume_cout", cout_pre, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
